// File: rtl/conv_out_packer_pkg.sv
// conv_out_packer_pkg
//   Shared definitions for the conv output packer: lane geometry, the
//   out_data_width mode encodings, the decoded bit-width selector and the
//   beats-per-word lookup, plus the packer FSM state type.
package conv_out_packer_pkg;

    localparam int TOUT      = 32;
    localparam int MAX_BN_DW = 8;
    localparam int PACK_W    = TOUT * MAX_BN_DW;

    localparam logic [2:0] ODW_8B = 3'b111;
    localparam logic [2:0] ODW_4B = 3'b011;
    localparam logic [2:0] ODW_2B = 3'b001;

    // Encoded value is log2 of the per-lane bit width.
    typedef enum logic [1:0] {
        BW_1 = 2'd0,
        BW_2 = 2'd1,
        BW_4 = 2'd2,
        BW_8 = 2'd3
    } bw_sel_e;

    typedef enum logic {
        P_EMPTY = 1'b0,
        P_PART  = 1'b1
    } pack_state_e;

    function automatic bw_sel_e decode_odw(input logic [2:0] odw);
        case (odw)
            ODW_8B:  return BW_8;
            ODW_4B:  return BW_4;
            ODW_2B:  return BW_2;
            default: return BW_1;
        endcase
    endfunction

    // Beats per packed word: MAX_BN_DW / b -> 1/2/4/8.
    function automatic logic [3:0] beats_per_word(input bw_sel_e m);
        return 4'(MAX_BN_DW >> int'(m));
    endfunction

endpackage

// File: rtl/conv_out_packer_fifo.sv
// conv_pack_fifo
//   Synchronous first-word-fall-through FIFO. Head data is read straight
//   from the storage registers, so a word written at an edge is visible on
//   rd_dat/rd_vld right after that edge. A push while full succeeds only if
//   a pop happens in the same cycle; otherwise it is dropped and flagged.
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   push, push_dat  write request and data
//   pop             read request (ignored when empty)
//   rd_vld, rd_dat  head valid / head data (zero when empty)
//   count           current occupancy
//   drop            push discarded this cycle because the FIFO was full
module conv_pack_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat,
    output logic [CW-1:0]    count,
    output logic             drop
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign do_pop  = pop && (count != '0);
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push && ((count < CW'(DEPTH)) || do_pop);
    assign drop    = push && !do_push;

    assign rd_vld  = (count != '0);
    // Gate stale storage so outputs read zero whenever the FIFO is empty.
    assign rd_dat  = rd_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/conv_out_packer.sv
// conv_out_packer
//   Compacts sub-byte conv result beats into dense TOUT*MAX_BN_DW words,
//   queues them in a FWFT FIFO and hands them to the write DMA over
//   valid/ready. Raises stall_o early enough to absorb in-flight beats.
//   Optional feature macro: CONV_PACK_STAT_EN adds stat_words_o (words
//   popped) and stat_stall_o (cycles with stall_o=1), both saturating.
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   out_data_width    3'b111=8b, 3'b011=4b, 3'b001=2b, other=1b
//   beat_vld_i/dat_i  result beat (no backpressure)
//   pack_flush_i      end of tile: close a partial word
//   stall_o           upstream stall request (registered)
//   wr_vld_o/rdy_i    packed word handshake; wr_dat_o/wr_last_o payload
//   busy_o            partial beats held, word pending, or FIFO non-empty
//   ovf_err_o         sticky: a word was dropped on a full FIFO
module conv_out_packer
    import conv_out_packer_pkg::*;
#(
    parameter int FIFO_DEPTH   = 16,
    parameter int AFULL_MARGIN = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        out_data_width,
    input  logic              beat_vld_i,
    input  logic [PACK_W-1:0] beat_dat_i,
    input  logic              pack_flush_i,
    output logic              stall_o,
    output logic              wr_vld_o,
    input  logic              wr_rdy_i,
    output logic [PACK_W-1:0] wr_dat_o,
    output logic              wr_last_o,
    output logic              busy_o,
    output logic              ovf_err_o
`ifdef CONV_PACK_STAT_EN
    ,
    output logic [31:0]       stat_words_o,
    output logic [31:0]       stat_stall_o
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    bw_sel_e     bw;
    logic [3:0]  nb;
    assign bw = decode_odw(out_data_width);
    assign nb = beats_per_word(bw);

    // Per-lane compaction: lane i keeps its low b bits at offset i*b.
    logic [TOUT*4-1:0] chunk4;
    logic [TOUT*2-1:0] chunk2;
    logic [TOUT-1:0]   chunk1;
    for (genvar i = 0; i < TOUT; i++) begin : g_lane
        assign chunk4[i*4 +: 4] = beat_dat_i[i*MAX_BN_DW +: 4];
        assign chunk2[i*2 +: 2] = beat_dat_i[i*MAX_BN_DW +: 2];
        assign chunk1[i]        = beat_dat_i[i*MAX_BN_DW];
    end

    logic [PACK_W-1:0] chunk;
    always_comb begin
        chunk = '0;
        case (bw)
            BW_8:    chunk = beat_dat_i;
            BW_4:    chunk = PACK_W'(chunk4);
            BW_2:    chunk = PACK_W'(chunk2);
            default: chunk = PACK_W'(chunk1);
        endcase
    end

    // Packer state
    pack_state_e       state, state_nxt;
    logic [3:0]        cnt, cnt_nxt, cnt_sum;
    logic [PACK_W-1:0] acc, acc_nxt, merged;
    logic [31:0]       shamt;
    logic              emit, emit_last;

    // Output staging register: a closed word is pushed the cycle after it closes.
    logic              push_vld, push_last;
    logic [PACK_W-1:0] push_dat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= P_EMPTY;
            cnt   <= '0;
            acc   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            acc   <= acc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc_nxt   = acc;
        merged    = acc;
        emit      = 1'b0;
        emit_last = 1'b0;
        // Slot j starts at j*TOUT*b.
        shamt     = 32'(cnt) * 32'(TOUT << int'(bw));
        if (beat_vld_i) merged = acc | (chunk << shamt);
        cnt_sum   = cnt + 4'(beat_vld_i);
        // A beat arriving with flush is folded in first; the flush then closes
        // the word, so a word completed by that same beat is emitted once, marked last.
        emit_last = pack_flush_i && (cnt_sum != '0);
        emit      = (beat_vld_i && (cnt_sum == nb)) || emit_last;
        if (emit) begin
            cnt_nxt   = '0;
            acc_nxt   = '0;
            state_nxt = P_EMPTY;
        end else begin
            cnt_nxt   = cnt_sum;
            acc_nxt   = merged;
            state_nxt = (cnt_sum != '0) ? P_PART : P_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            push_vld  <= 1'b0;
            push_last <= 1'b0;
            push_dat  <= '0;
        end else begin
            push_vld  <= emit;
            push_last <= emit_last;
            push_dat  <= merged;
        end
    end

    // FIFO carries {last, data}.
    logic [PACK_W:0] fifo_rd;
    logic [CW-1:0]   fifo_cnt;
    logic            fifo_drop;

    conv_pack_fifo #(
        .WIDTH (PACK_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_vld),
        .push_dat ({push_last, push_dat}),
        .pop      (wr_rdy_i),
        .rd_vld   (wr_vld_o),
        .rd_dat   (fifo_rd),
        .count    (fifo_cnt),
        .drop     (fifo_drop)
    );

    assign wr_dat_o  = fifo_rd[PACK_W-1:0];
    assign wr_last_o = fifo_rd[PACK_W];
    assign busy_o    = (state != P_EMPTY) || push_vld || (fifo_cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_o   <= 1'b0;
            ovf_err_o <= 1'b0;
        end else begin
            stall_o   <= (fifo_cnt >= CW'(FIFO_DEPTH - AFULL_MARGIN));
            ovf_err_o <= ovf_err_o | fifo_drop;
        end
    end

`ifdef CONV_PACK_STAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_words_o <= '0;
            stat_stall_o <= '0;
        end else begin
            if (wr_vld_o && wr_rdy_i && (stat_words_o != 32'hFFFF_FFFF))
                stat_words_o <= stat_words_o + 32'd1;
            if (stall_o && (stat_stall_o != 32'hFFFF_FFFF))
                stat_stall_o <= stat_stall_o + 32'd1;
        end
    end
`endif

endmodule
